// File: rtl/int_denorm_if.sv
// Request/response bundle for the multi-cycle denormalizing right shifter.
interface int_denorm_if #(
  parameter int unsigned WIDTH = 64
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] X;
  logic [SHW-1:0]   Shamt;
  logic             Signed;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Y;
  logic             Sticky;
  logic             Busy;

  modport master (
    output InValid, X, Shamt, Signed, OutReady,
    input  InReady, OutValid, Y, Sticky, Busy
  );

  modport slave (
    input  InValid, X, Shamt, Signed, OutReady,
    output InReady, OutValid, Y, Sticky, Busy
  );
endinterface

// File: rtl/int_denorm.sv
// Replays an LZD count as a right shift of up to STEP bits per cycle, collecting
// a sticky bit of everything shifted out; one request in flight at a time.
module int_denorm #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned STEP  = 8
) (
  input  logic       clk,
  input  logic       reset,
  int_denorm_if.slave io
);
  localparam int unsigned SHW = $clog2(WIDTH);
  // STEP may equal WIDTH, which needs one bit more than the shift amount
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [SHW-1:0]   rem, rem_nxt;
  logic [SHW-1:0]   s;
  logic             fill, fill_nxt;
  logic             sticky, sticky_nxt;
  logic             in_ready, out_valid, busy;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mask;

  // Next-state and datapath update
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    rem_nxt    = rem;
    fill_nxt   = fill;
    sticky_nxt = sticky;
    s          = ({1'b0, rem} < STEP_W) ? rem : SHW'(STEP);
    shifted    = WIDTH'({{WIDTH{fill}}, acc} >> s);
    mask       = (WIDTH'(1) << s) - WIDTH'(1);
    case (state)
      IDLE: begin
        if (io.InValid) begin
          acc_nxt    = io.X;
          rem_nxt    = io.Shamt;
          fill_nxt   = io.Signed & io.X[WIDTH-1];
          sticky_nxt = 1'b0;
          state_nxt  = (io.Shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_nxt    = shifted;
        sticky_nxt = sticky | (|(acc & mask));
        rem_nxt    = rem - s;
        if (rem_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (io.OutReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and handshake flags; flags follow the next state so they are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      rem       <= '0;
      fill      <= 1'b0;
      sticky    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      rem       <= rem_nxt;
      fill      <= fill_nxt;
      sticky    <= sticky_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

  assign io.InReady  = in_ready;
  assign io.OutValid = out_valid;
  assign io.Busy     = busy;
  assign io.Y        = acc;
  assign io.Sticky   = sticky;
endmodule

// File: tb/tb_int_denorm.sv
// Bench for int_denorm: directed vector table, stall/reset corner cases and
// randomized traffic against an arithmetic reference model.
module tb_int_denorm;
  localparam int unsigned W    = 64;
  localparam int unsigned STEP = 8;
  localparam int unsigned SHW  = $clog2(W);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int_denorm_if #(.WIDTH(W)) bus ();

  int_denorm #(.WIDTH(W), .STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] x;
    int          sh;
    logic        sg;
    logic [63:0] y;
    logic        st;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: shift result, shifted-out OR, and cycles from accept to OutValid
  function automatic void model(input logic [63:0] x, input int sh, input logic sg,
                                output logic [63:0] y, output logic st, output int lat);
    y   = sg ? 64'($signed(x) >>> sh) : (x >> sh);
    st  = |(x & ((64'd1 << sh) - 64'd1));
    lat = 1 + (sh + int'(STEP) - 1) / int'(STEP);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [63:0] x, input int sh, input logic sg, input int stalls,
                        input bit poke, input logic [63:0] ey, input logic est, input int elat,
                        input string tag);
    int lat;
    int low;
    logic [63:0] y0;
    logic st0;
    check({tag, "_inready_idle"}, 64'(bus.InReady), 64'd1);
    bus.InValid  = 1'b1;
    bus.X        = x;
    bus.Shamt    = SHW'(sh);
    bus.Signed   = sg;
    bus.OutReady = 1'b0;
    tick;
    // Scramble inputs after the accept edge; optionally keep InValid high
    bus.InValid = poke;
    bus.X       = {$urandom, $urandom};
    bus.Shamt   = SHW'($urandom);
    bus.Signed  = 1'($urandom);
    check({tag, "_busy"}, 64'(bus.Busy), 64'd1);
    lat = 1;
    low = int'(!bus.InReady);
    while (!bus.OutValid && lat < 200) begin
      tick;
      lat++;
      low += int'(!bus.InReady);
    end
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    bus.InValid = 1'b0;
    y0  = bus.Y;
    st0 = bus.Sticky;
    for (int k = 0; k < stalls; k++) begin
      tick;
      low += int'(!bus.InReady);
      check({tag, "_stall_valid"}, 64'(bus.OutValid), 64'd1);
      check({tag, "_stall_y"}, bus.Y, y0);
      check({tag, "_stall_sticky"}, 64'(bus.Sticky), 64'(st0));
    end
    check({tag, "_y"}, y0, ey);
    check({tag, "_sticky"}, 64'(st0), 64'(est));
    bus.OutReady = 1'b1;
    tick;
    bus.OutReady = 1'b0;
    check({tag, "_valid_after"}, 64'(bus.OutValid), 64'd0);
    check({tag, "_inready_after"}, 64'(bus.InReady), 64'd1);
    check({tag, "_inready_low_cycles"}, 64'(low), 64'(elat + stalls));
  endtask

  initial begin
    logic [63:0] rx, ey;
    logic        rsg, est;
    int          rsh, elat;

    vecs[0] = '{64'h8000_0000_0000_0000, 63, 1'b0, 64'h0000_0000_0000_0001, 1'b0, 9};
    vecs[1] = '{64'hF000_0000_0000_0001,  4, 1'b1, 64'hFF00_0000_0000_0000, 1'b1, 2};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0,  0, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF,  1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 2};
    vecs[4] = '{64'h8000_0000_0000_0000,  8, 1'b1, 64'hFF80_0000_0000_0000, 1'b0, 2};
    vecs[5] = '{64'h0000_0000_0000_00FF,  9, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 3};
    vecs[6] = '{64'h8000_0000_0000_0000, 63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 9};
    vecs[7] = '{64'h0123_4567_89AB_CDEF, 16, 1'b1, 64'h0000_0123_4567_89AB, 1'b1, 3};

    bus.InValid  = 1'b0;
    bus.X        = '0;
    bus.Shamt    = '0;
    bus.Signed   = 1'b0;
    bus.OutReady = 1'b0;
    reset        = 1'b1;
    repeat (3) tick;
    check("rst_inready", 64'(bus.InReady), 64'd1);
    check("rst_outvalid", 64'(bus.OutValid), 64'd0);
    check("rst_y", bus.Y, 64'd0);
    check("rst_sticky", 64'(bus.Sticky), 64'd0);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    reset = 1'b0;
    tick;

    foreach (vecs[i])
      run_op(vecs[i].x, vecs[i].sh, vecs[i].sg, 0, 1'b0,
             vecs[i].y, vecs[i].st, vecs[i].lat, $sformatf("vec%0d", i));

    // Long consumer stall with InValid asserted during SHIFT
    rx = 64'hC3A5_0F0F_1234_8765;
    model(rx, 20, 1'b1, ey, est, elat);
    run_op(rx, 20, 1'b1, 5, 1'b1, ey, est, elat, "stall20");

    // Reset during the second SHIFT cycle of a 40-bit shift
    bus.InValid = 1'b1;
    bus.X       = 64'hDEAD_BEEF_CAFE_F00D;
    bus.Shamt   = SHW'(40);
    bus.Signed  = 1'b1;
    tick;
    bus.InValid = 1'b0;
    check("abort_busy", 64'(bus.Busy), 64'd1);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_inready", 64'(bus.InReady), 64'd1);
    check("abort_outvalid", 64'(bus.OutValid), 64'd0);
    check("abort_y", bus.Y, 64'd0);
    check("abort_sticky", 64'(bus.Sticky), 64'd0);
    bus.OutReady = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      check("abort_no_stale", 64'(bus.OutValid), 64'd0);
    end
    bus.OutReady = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      rx  = {$urandom, $urandom};
      rsh = int'($urandom_range(0, W - 1));
      rsg = 1'($urandom);
      model(rx, rsh, rsg, ey, est, elat);
      run_op(rx, rsh, rsg, int'($urandom_range(0, 3)), 1'($urandom), ey, est, elat,
             $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
